hazard_forward_ctrl: RTL

//  Parametrised forwarding and hazard control for the pipelined MIPS core; sits beside the ID/EX register.

---
 rtl/hazard_pkg.sv | 16 +
 rtl/hazard_forward_ctrl_if.sv | 38 +++
 rtl/hazard_forward_ctrl_fwd_select.sv | 27 ++
 rtl/hazard_forward_ctrl.sv | 88 ++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the forwarding / load-use hazard controller.
package hazard_pkg;

  localparam int FWD_RF = 0;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  // Width of an operand-select field able to encode the register file plus n sources
  function automatic int sel_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// Pipeline-side bundle of the hazard/forwarding controller; the controller takes the slave view.
interface hazard_forward_ctrl_if #(
  parameter int REG_AW   = 5,
  parameter int FWD_SRCS = 2,
  parameter int CNT_W    = 32
);
  import hazard_pkg::*;

  localparam int SELW = sel_w(FWD_SRCS);

  logic [REG_AW-1:0]          id_ex_rs;
  logic [REG_AW-1:0]          id_ex_rt;
  logic                       id_ex_memread;
  logic [REG_AW-1:0]          if_id_rs;
  logic [REG_AW-1:0]          if_id_rt;
  logic [FWD_SRCS-1:0]        src_regwrite;
  logic [FWD_SRCS*REG_AW-1:0] src_rd;
  logic                       mem_busy;
  logic                       flush;
  logic [SELW-1:0]            fwd_a;
  logic [SELW-1:0]            fwd_b;
  logic                       stall;
  logic                       bubble;
  logic [CNT_W-1:0]           stall_cycles;

  modport master (
    output id_ex_rs, id_ex_rt, id_ex_memread, if_id_rs, if_id_rt,
           src_regwrite, src_rd, mem_busy, flush,
    input  fwd_a, fwd_b, stall, bubble, stall_cycles
  );

  modport slave (
    input  id_ex_rs, id_ex_rt, id_ex_memread, if_id_rs, if_id_rt,
           src_regwrite, src_rd, mem_busy, flush,
    output fwd_a, fwd_b, stall, bubble, stall_cycles
  );

endinterface

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// Priority match of one ALU operand against all forwarding sources; youngest source wins.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int FWD_SRCS = 2,
  parameter int SELW     = sel_w(FWD_SRCS)
) (
  input  logic [REG_AW-1:0]          operand,
  input  logic [FWD_SRCS-1:0]        src_regwrite,
  input  logic [FWD_SRCS*REG_AW-1:0] src_rd,
  output logic [SELW-1:0]            sel
);

  // Scan oldest to youngest so the lowest matching index is written last
  always_comb begin
    sel = SELW'(FWD_RF);
    for (int i = FWD_SRCS - 1; i >= 0; i--) begin
      if (src_regwrite[i] &&
          src_rd[i*REG_AW +: REG_AW] != '0 &&
          src_rd[i*REG_AW +: REG_AW] == operand) begin
        sel = SELW'(FWD_SRCS - i);
      end
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Operand forwarding plus load-use stall FSM with memory-busy extension and stall statistics.
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int FWD_SRCS = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_forward_ctrl_if.slave bus
);

  localparam int SELW = sel_w(FWD_SRCS);
  localparam int CW   = $clog2(LOAD_LAT + 1);

  logic [SELW-1:0]  sel_a;
  logic [SELW-1:0]  sel_b;
  logic             haz;
  logic             stall_int;
  state_e           state;
  logic [CW-1:0]    cnt;
  logic [CNT_W-1:0] stall_cnt;

  fwd_select #(.REG_AW(REG_AW), .FWD_SRCS(FWD_SRCS), .SELW(SELW)) u_sel_a (
    .operand      (bus.id_ex_rs),
    .src_regwrite (bus.src_regwrite),
    .src_rd       (bus.src_rd),
    .sel          (sel_a)
  );

  fwd_select #(.REG_AW(REG_AW), .FWD_SRCS(FWD_SRCS), .SELW(SELW)) u_sel_b (
    .operand      (bus.id_ex_rt),
    .src_regwrite (bus.src_regwrite),
    .src_rd       (bus.src_rd),
    .sel          (sel_b)
  );

  assign bus.fwd_a = rst ? '0 : sel_a;
  assign bus.fwd_b = rst ? '0 : sel_b;

  assign haz = bus.id_ex_memread && (bus.id_ex_rt != '0) &&
               ((bus.id_ex_rt == bus.if_id_rs) || (bus.id_ex_rt == bus.if_id_rt));

  // The detection cycle stalls combinationally; STALL covers the remaining cycles
  assign stall_int        = rst ? 1'b0 : ((state == ST_STALL) ? 1'b1 : haz);
  assign bus.stall        = stall_int;
  assign bus.bubble       = stall_int;
  assign bus.stall_cycles = stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (haz && !bus.flush && ((LOAD_LAT > 1) || bus.mem_busy)) begin
            state <= ST_STALL;
            cnt   <= CW'(LOAD_LAT - 1);
          end
        end
        ST_STALL: begin
          if (bus.flush) begin
            state <= ST_IDLE;
          end else if (bus.mem_busy) begin
            cnt <= cnt;
          end else if (cnt > CW'(1)) begin
            cnt <= cnt - CW'(1);
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_int && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
